// File: rtl/hmmm_pkg.sv
// Shared types and default widths for the hmmm processor memory.
package hmmm_pkg;

   typedef enum logic {
      MS_LOAD = 1'b0,
      MS_RUN  = 1'b1
   } mem_state_t;

   localparam int HMMM_ADDR_WIDTH  = 8;
   localparam int HMMM_INSTR_WIDTH = 15;
   localparam int HMMM_DATA_WIDTH  = 8;

endpackage

// File: rtl/hmmm_memory_mem_array.sv
// Word store: one synchronous write port, one asynchronous read port, no reset on contents.
module mem_array #(
   parameter int ADDR_WIDTH = 8,
   parameter int WIDTH      = 15
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] wa,
   input  logic [WIDTH-1:0]      wd,
   input  logic [ADDR_WIDTH-1:0] ra,
   output logic [WIDTH-1:0]      rd
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[wa] <= wd;
      end
   end

   assign rd = mem_q[ra];

endmodule

// File: rtl/hmmm_memory.sv
// Unified instruction/data memory with a boot-loader fill port; holds the core until loading ends.
module hmmm_memory
   import hmmm_pkg::*;
#(
   parameter int ADDR_WIDTH  = HMMM_ADDR_WIDTH,
   parameter int INSTR_WIDTH = HMMM_INSTR_WIDTH,
   parameter int DATA_WIDTH  = HMMM_DATA_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   MemWrite,
   input  logic [ADDR_WIDTH-1:0]  adr,
   input  logic [DATA_WIDTH-1:0]  WriteData,
   output logic [INSTR_WIDTH-1:0] ReadData,
   input  logic                   load_valid,
   input  logic [INSTR_WIDTH-1:0] load_data,
   input  logic                   load_last,
   output logic                   load_ready,
   input  logic                   load_start,
   output logic                   cpu_hold,
   output logic                   load_full
);

   mem_state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic                  full_q, full_d;

   logic                   xfer;
   logic                   core_we;
   logic                   we;
   logic [ADDR_WIDTH-1:0]  wa;
   logic [INSTR_WIDTH-1:0] wd;
   logic [INSTR_WIDTH-1:0] rd;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= MS_LOAD;
         ptr_q   <= '0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         full_q  <= full_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      full_d  = full_q;
      xfer    = 1'b0;
      core_we = 1'b0;
      unique case (state_q)
         MS_LOAD: begin
            xfer = load_valid;
            if (load_valid) begin
               ptr_d = ptr_q + 1'b1;
               if (load_last) begin
                  state_d = MS_RUN;
               end else if (ptr_q == '1) begin
                  // Ran out of address space without a terminating word.
                  state_d = MS_RUN;
                  full_d  = 1'b1;
               end
            end
         end
         MS_RUN: begin
            core_we = MemWrite;
            if (load_start) begin
               state_d = MS_LOAD;
               ptr_d   = '0;
               full_d  = 1'b0;
            end
         end
         default: begin
            state_d = MS_LOAD;
         end
      endcase
   end

   // States are exclusive, so at most one of loader/core drives the write port.
   assign we = xfer | core_we;
   assign wa = xfer ? ptr_q : adr;
   assign wd = xfer ? load_data : {{(INSTR_WIDTH-DATA_WIDTH){1'b0}}, WriteData};

   mem_array #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .WIDTH     (INSTR_WIDTH)
   ) u_mem_array (
      .clk(clk),
      .we (we),
      .wa (wa),
      .wd (wd),
      .ra (adr),
      .rd (rd)
   );

   assign ReadData   = (state_q == MS_RUN) ? rd : '0;
   assign load_ready = (state_q == MS_LOAD);
   assign cpu_hold   = (state_q == MS_LOAD);
   assign load_full  = full_q;

endmodule

// File: tb/tb_hmmm_memory.sv
// Randomized self-checking bench for hmmm_memory against a behavioural memory model.
module tb_hmmm_memory;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite;
   logic [7:0]  adr;
   logic [7:0]  WriteData;
   logic [14:0] ReadData;
   logic        load_valid;
   logic [14:0] load_data;
   logic        load_last;
   logic        load_ready;
   logic        load_start;
   logic        cpu_hold;
   logic        load_full;

   int tests  = 0;
   int errors = 0;

   // Reference model: loader mode flag, fill position, sticky full, word image.
   bit          m_loading;
   int          m_ptr;
   bit          m_full;
   logic [14:0] m_mem [256];
   bit          m_known [256];

   always #5 clk = ~clk;

   hmmm_memory dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .adr       (adr),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .load_valid(load_valid),
      .load_data (load_data),
      .load_last (load_last),
      .load_ready(load_ready),
      .load_start(load_start),
      .cpu_hold  (cpu_hold),
      .load_full (load_full)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic idle();
      MemWrite   = 1'b0;
      adr        = '0;
      WriteData  = '0;
      load_valid = 1'b0;
      load_data  = '0;
      load_last  = 1'b0;
      load_start = 1'b0;
   endtask

   // Compare current outputs, advance the model by one clock using the driven inputs, clock.
   task automatic tick(input string tag);
      #1;
      check({tag, " cpu_hold"},   cpu_hold,   m_loading);
      check({tag, " load_ready"}, load_ready, m_loading);
      check({tag, " load_full"},  load_full,  m_full);
      if (m_loading)
         check({tag, " rdata_load"}, ReadData, 15'h0);
      else if (m_known[adr])
         check({tag, " rdata"}, ReadData, m_mem[adr]);
      if (m_loading) begin
         if (load_valid) begin
            m_mem[m_ptr]   = load_data;
            m_known[m_ptr] = 1'b1;
            if (load_last) m_loading = 1'b0;
            else if (m_ptr == 255) begin
               m_loading = 1'b0;
               m_full    = 1'b1;
            end
            m_ptr = (m_ptr + 1) % 256;
         end
      end else begin
         if (MemWrite) begin
            m_mem[adr]   = {7'h0, WriteData};
            m_known[adr] = 1'b1;
         end
         if (load_start) begin
            m_loading = 1'b1;
            m_ptr     = 0;
            m_full    = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle();
      #2 reset = 1'b1;
      #1;
      m_loading = 1'b1;
      m_ptr     = 0;
      m_full    = 1'b0;
      check("reset cpu_hold",   cpu_hold,   1'b1);
      check("reset load_ready", load_ready, 1'b1);
      check("reset load_full",  load_full,  1'b0);
      check("reset rdata",      ReadData,   15'h0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic load_word(input logic [14:0] d, input bit last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      tick("load");
      idle();
   endtask

   task automatic read_at(input logic [7:0] a, input logic [14:0] exp, input string tag);
      idle();
      adr = a;
      #1;
      check(tag, ReadData, exp);
      tick(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation ran past its time limit");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      reset = 1'b0;
      m_loading = 1'b1;
      m_ptr = 0;
      m_full = 1'b0;
      for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
      @(negedge clk);
      do_reset();

      // 1: three-word load, hold released after the terminating word
      load_word(15'h0101, 1'b0);
      load_word(15'h0202, 1'b0);
      check("t1 hold before last", cpu_hold, 1'b1);
      load_word(15'h7FFF, 1'b1);
      check("t1 hold after last", cpu_hold, 1'b0);
      read_at(8'd0, 15'h0101, "t1 rd0");
      read_at(8'd1, 15'h0202, "t1 rd1");
      read_at(8'd2, 15'h7FFF, "t1 rd2");

      // 3: store visible the cycle after, old word in the same cycle
      read_at(8'h10, m_known[8'h10] ? m_mem[8'h10] : 15'h0, "t3 prime");
      idle();
      adr = 8'h10; WriteData = 8'hA5; MemWrite = 1'b1;
      tick("t3 write");
      read_at(8'h10, 15'h00A5, "t3 new");

      // 2: gapped loader handshake, 10 words
      load_start = 1'b1;
      tick("t2 start");
      idle();
      for (int n = 0; n < 10; ) begin
         load_valid = ($urandom_range(0, 2) != 0);
         load_data  = 15'($urandom);
         load_last  = (n == 9);
         adr        = 8'($urandom);
         MemWrite   = 1'($urandom);
         if (load_valid) n++;
         tick("t2 load");
         idle();
      end
      for (int a = 0; a < 10; a++) read_at(8'(a), m_mem[a], "t2 rd");

      // 4: full fill without load_last
      load_start = 1'b1;
      tick("t4 start");
      for (int n = 0; n < 256; n++) begin
         idle();
         load_valid = 1'b1;
         load_data  = 15'($urandom);
         tick("t4 load");
      end
      idle();
      check("t4 load_full", load_full, 1'b1);
      check("t4 cpu_hold", cpu_hold, 1'b0);
      read_at(8'hFF, m_mem[255], "t4 rdFF");

      // 6: restart request with a same-cycle store
      idle();
      adr = 8'd3; WriteData = 8'h5C; MemWrite = 1'b1; load_start = 1'b1;
      tick("t6 start");
      idle();
      check("t6 cpu_hold", cpu_hold, 1'b1);
      check("t6 load_full", load_full, 1'b0);
      check("t6 rdata", ReadData, 15'h0);
      load_word(15'h1111, 1'b0);
      load_word(15'h2222, 1'b1);
      read_at(8'd3, 15'h005C, "t6 store kept");
      read_at(8'd1, 15'h2222, "t6 rd1");

      // 5: reset mid-load, then a clean reload
      load_start = 1'b1;
      tick("t5 start");
      idle();
      load_word(15'h0AAA, 1'b0);
      load_word(15'h0BBB, 1'b0);
      do_reset();
      for (int n = 0; n < 5; n++) load_word(15'(16'h4000 + n), n == 4);
      for (int a = 0; a < 5; a++) read_at(8'(a), 15'(16'h4000 + a), "t5 rd");

      // Random mixed traffic
      for (int c = 0; c < 3000; c++) begin
         idle();
         adr        = 8'($urandom);
         WriteData  = 8'($urandom);
         MemWrite   = ($urandom_range(0, 2) == 0);
         load_valid = 1'($urandom);
         load_data  = 15'($urandom);
         load_last  = ($urandom_range(0, 7) == 0);
         load_start = ($urandom_range(0, 60) == 0);
         tick("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
